// File: rtl/ixu_pkg.sv
// rtl/ixu_pkg.sv - shared constants and types for the IXU register file
package ixu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_AW    = 5;
  localparam int LANES_DEF = 2;

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/ixu_regfile_if.sv
// rtl/ixu_regfile_if.sv - per-lane read, forward and writeback bus between IXU lanes and the register file
interface ixu_regfile_if
  import ixu_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int XLEN  = XLEN_DEF
);

  reg_addr_t [LANES-1:0]           rs1_addr;
  reg_addr_t [LANES-1:0]           rs2_addr;
  logic      [LANES-1:0][XLEN-1:0] rs1_data;
  logic      [LANES-1:0][XLEN-1:0] rs2_data;
  logic      [LANES-1:0]           is_rs1_fwd;
  logic      [LANES-1:0]           is_rs2_fwd;
  logic      [LANES-1:0][XLEN-1:0] rs1_fwd_data;
  logic      [LANES-1:0][XLEN-1:0] rs2_fwd_data;
  reg_addr_t [LANES-1:0]           wr_addr;
  logic      [LANES-1:0][XLEN-1:0] wr_data;
  logic      [LANES-1:0]           wr_en;

  modport master (
    output rs1_addr, rs2_addr, wr_addr, wr_data, wr_en,
    input  rs1_data, rs2_data, is_rs1_fwd, is_rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_addr, wr_data, wr_en,
    output rs1_data, rs2_data, is_rs1_fwd, is_rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );

endinterface

// File: rtl/ixu_regfile_fwd_mux.sv
// rtl/ixu_regfile_fwd_mux.sv - priority match of one read address against all lane write ports
module ixu_regfile_fwd_mux
  import ixu_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  reg_addr_t                       rd_addr,
  input  reg_addr_t [LANES-1:0]           wr_addr,
  input  logic      [LANES-1:0][XLEN-1:0] wr_data,
  input  logic      [LANES-1:0]           wr_en,
  output logic                            hit,
  output logic      [XLEN-1:0]            data
);

  // Ascending scan so the highest-index lane wins, matching the storage write order.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < LANES; j++) begin
      if (wr_en[j] && (wr_addr[j] == rd_addr) && (rd_addr != '0)) begin
        hit  = 1'b1;
        data = wr_data[j];
      end
    end
  end

endmodule

// File: rtl/ixu_regfile.sv
// rtl/ixu_regfile.sv - shared multi-lane integer register file with forwarding and collision statistics
module ixu_regfile
  import ixu_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ixu_regfile_if.slave      rf,
  input  logic              clr_err,
  output logic              wr_collision,
  output logic [15:0]       collision_count,
  input  reg_addr_t         dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [XLEN-1:0] view [NREGS];
  logic            collision;

  // Later lanes overwrite earlier ones in the unrolled loop, giving highest-index priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        for (int j = 0; j < LANES; j++) begin
          if (rf.wr_en[j] && (rf.wr_addr[j] == reg_addr_t'(r))) regs[r] <= rf.wr_data[j];
        end
      end
    end
  end

  always_comb begin
    view[0] = '0;
    for (int r = 1; r < NREGS; r++) view[r] = regs[r];
  end

  assign dbg_data = view[dbg_addr];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign rf.rs1_data[l] = view[rf.rs1_addr[l]];
    assign rf.rs2_data[l] = view[rf.rs2_addr[l]];

    ixu_regfile_fwd_mux #(.LANES(LANES), .XLEN(XLEN)) u_fwd_rs1 (
      .rd_addr (rf.rs1_addr[l]),
      .wr_addr (rf.wr_addr),
      .wr_data (rf.wr_data),
      .wr_en   (rf.wr_en),
      .hit     (rf.is_rs1_fwd[l]),
      .data    (rf.rs1_fwd_data[l])
    );

    ixu_regfile_fwd_mux #(.LANES(LANES), .XLEN(XLEN)) u_fwd_rs2 (
      .rd_addr (rf.rs2_addr[l]),
      .wr_addr (rf.wr_addr),
      .wr_data (rf.wr_data),
      .wr_en   (rf.wr_en),
      .hit     (rf.is_rs2_fwd[l]),
      .data    (rf.rs2_fwd_data[l])
    );
  end

  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (rf.wr_en[i] && rf.wr_en[j] && (rf.wr_addr[i] == rf.wr_addr[j]) && (rf.wr_addr[i] != '0))
          collision = 1'b1;
      end
    end
  end

  // Clear takes priority over a collision in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_collision    <= 1'b0;
      collision_count <= '0;
    end else if (clr_err) begin
      wr_collision    <= 1'b0;
      collision_count <= '0;
    end else if (collision) begin
      wr_collision <= 1'b1;
      if (collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ixu_regfile.sv
// tb/tb_ixu_regfile.sv - scoreboard bench for ixu_regfile
module tb_ixu_regfile;
  import ixu_pkg::*;

  localparam int LANES = 2;
  localparam int XLEN  = 32;

  localparam int S_RS1D0 = 0,  S_RS1D1 = 1,  S_RS2D0 = 2,  S_RS2D1 = 3;
  localparam int S_FWD1  = 4,  S_FWD2  = 5;
  localparam int S_RS1F0 = 6,  S_RS1F1 = 7,  S_RS2F0 = 8,  S_RS2F1 = 9;
  localparam int S_FLAG  = 10, S_CNT   = 11, S_DBG   = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_err;
  logic              wr_collision;
  logic [15:0]       collision_count;
  reg_addr_t         dbg_addr;
  logic [XLEN-1:0]   dbg_data;

  ixu_regfile_if #(.LANES(LANES), .XLEN(XLEN)) bus ();

  ixu_regfile #(.LANES(LANES), .XLEN(XLEN), .NREGS(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .rf              (bus.slave),
    .clr_err         (clr_err),
    .wr_collision    (wr_collision),
    .collision_count (collision_count),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RS1D0: return bus.rs1_data[0];
      S_RS1D1: return bus.rs1_data[1];
      S_RS2D0: return bus.rs2_data[0];
      S_RS2D1: return bus.rs2_data[1];
      S_FWD1:  return {30'b0, bus.is_rs1_fwd};
      S_FWD2:  return {30'b0, bus.is_rs2_fwd};
      S_RS1F0: return bus.rs1_fwd_data[0];
      S_RS1F1: return bus.rs1_fwd_data[1];
      S_RS2F0: return bus.rs2_fwd_data[0];
      S_RS2F1: return bus.rs2_fwd_data[1];
      S_FLAG:  return {31'b0, wr_collision};
      S_CNT:   return {16'b0, collision_count};
      S_DBG:   return dbg_data;
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.sel = sel;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic drain();
    exp_t item;
    while (sb.size() > 0) begin
      item = sb.pop_front();
      check(item.tag, observe(item.sel), item.exp);
    end
  endtask

  task automatic set_wr(input int lane, input logic en, input int addr, input logic [31:0] data);
    bus.wr_en[lane]   = en;
    bus.wr_addr[lane] = reg_addr_t'(addr);
    bus.wr_data[lane] = data;
  endtask

  initial begin
    rst = 1'b1;
    clr_err = 1'b0;
    dbg_addr = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_en    = '0;
    repeat (2) @(negedge clk);

    rst = 1'b0;
    expect_val("reset_count", S_CNT, 32'h0);
    expect_val("reset_flag", S_FLAG, 32'h0);
    expect_val("reset_rs1d0", S_RS1D0, 32'h0);
    #1 drain();

    // r0 write is discarded and never forwarded
    @(negedge clk);
    set_wr(0, 1'b1, 0, 32'hDEAD);
    bus.rs1_addr[1] = 5'd0;
    expect_val("r0_no_fwd", S_FWD1, 32'h0);
    expect_val("r0_fwd_data", S_RS1F1, 32'h0);
    #1 drain();

    @(negedge clk);
    set_wr(0, 1'b0, 0, 32'h0);
    expect_val("r0_reads_zero", S_RS1D1, 32'h0);
    expect_val("r0_dbg_zero", S_DBG, 32'h0);
    #1 drain();

    // write-then-read with same-cycle forwarding
    @(negedge clk);
    set_wr(0, 1'b1, 5, 32'h1234);
    bus.rs1_addr[1] = 5'd5;
    expect_val("wr_rd_old", S_RS1D1, 32'h0);
    expect_val("wr_rd_fwd_flag", S_FWD1, 32'h2);
    expect_val("wr_rd_fwd_data", S_RS1F1, 32'h1234);
    #1 drain();

    @(negedge clk);
    set_wr(0, 1'b0, 0, 32'h0);
    expect_val("wr_rd_next", S_RS1D1, 32'h1234);
    expect_val("wr_rd_next_fwd", S_FWD1, 32'h0);
    #1 drain();

    // collision priority, held for 3 more cycles
    @(negedge clk);
    set_wr(0, 1'b1, 7, 32'h1);
    set_wr(1, 1'b1, 7, 32'h2);
    bus.rs1_addr[0] = 5'd7;
    expect_val("col_fwd_data", S_RS1F0, 32'h2);
    expect_val("col_fwd_flag", S_FWD1, 32'h1);
    expect_val("col_pre_flag", S_FLAG, 32'h0);
    expect_val("col_pre_count", S_CNT, 32'h0);
    #1 drain();

    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) bus.wr_en = '0;
      expect_val("col_stored", S_RS1D0, 32'h2);
      expect_val("col_flag", S_FLAG, 32'h1);
      expect_val($sformatf("col_count_%0d", k), S_CNT, 32'(k));
      #1 drain();
    end

    // dual-source forwarding, dbg port unforwarded
    @(negedge clk);
    set_wr(0, 1'b1, 4, 32'hB);
    set_wr(1, 1'b1, 3, 32'hA);
    bus.rs1_addr[0] = 5'd3;
    bus.rs2_addr[0] = 5'd4;
    dbg_addr = 5'd3;
    expect_val("dual_fwd1", S_FWD1, 32'h1);
    expect_val("dual_fwd2", S_FWD2, 32'h1);
    expect_val("dual_rs1f", S_RS1F0, 32'hA);
    expect_val("dual_rs2f", S_RS2F0, 32'hB);
    expect_val("dual_dbg_old", S_DBG, 32'h0);
    expect_val("dual_rs1_old", S_RS1D0, 32'h0);
    expect_val("dual_no_col", S_CNT, 32'h4);
    #1 drain();

    @(negedge clk);
    bus.wr_en = '0;
    expect_val("dual_dbg_new", S_DBG, 32'hA);
    expect_val("dual_rs1_new", S_RS1D0, 32'hA);
    expect_val("dual_rs2_new", S_RS2D0, 32'hB);
    #1 drain();

    // clear wins over a same-cycle collision
    @(negedge clk);
    set_wr(0, 1'b1, 7, 32'h5);
    set_wr(1, 1'b1, 7, 32'h6);
    clr_err = 1'b1;
    #1 drain();

    @(negedge clk);
    clr_err = 1'b0;
    bus.wr_en = '0;
    expect_val("clr_flag", S_FLAG, 32'h0);
    expect_val("clr_count", S_CNT, 32'h0);
    #1 drain();

    // saturation
    @(negedge clk);
    set_wr(0, 1'b1, 9, 32'h1);
    set_wr(1, 1'b1, 9, 32'h2);
    repeat (65540) @(negedge clk);
    bus.wr_en = '0;
    expect_val("sat_count", S_CNT, 32'hFFFF);
    expect_val("sat_flag", S_FLAG, 32'h1);
    #1 drain();

    @(negedge clk);
    expect_val("sat_hold", S_CNT, 32'hFFFF);
    #1 drain();

    // asynchronous reset mid-cycle with stored data; forwarding stays live
    @(negedge clk);
    set_wr(0, 1'b1, 10, 32'h55);
    bus.rs2_addr[0] = 5'd10;
    bus.rs1_addr[1] = 5'd5;
    dbg_addr = 5'd3;
    #2 rst = 1'b1;
    expect_val("rst_rs1d1", S_RS1D1, 32'h0);
    expect_val("rst_dbg", S_DBG, 32'h0);
    expect_val("rst_count", S_CNT, 32'h0);
    expect_val("rst_flag", S_FLAG, 32'h0);
    expect_val("rst_fwd_live", S_FWD2, 32'h1);
    expect_val("rst_fwd_data", S_RS2F0, 32'h55);
    #1 drain();

    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = '0;
    expect_val("rst_write_dropped", S_RS2D0, 32'h0);
    #1 drain();

    @(negedge clk);
    set_wr(0, 1'b1, 10, 32'h77);
    @(negedge clk);
    bus.wr_en = '0;
    expect_val("post_rst_write", S_RS2D0, 32'h77);
    #1 drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
